// File: rtl/multi_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : multi_button_debounce
// Description : N-channel push-button conditioner. Each raw input is
//               synchronised, then accepted only after holding a new level
//               for a full stability window (a bounce restarts the window).
//               Per channel: debounced level plus one-cycle press, release
//               and long-press strobes; any_press is the OR of press strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_button_debounce #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 200_000,
    parameter int LONG_CYCLES   = 40_000_000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] btn_in_i,
    output logic [N_CH-1:0] btn_level_o,
    output logic [N_CH-1:0] btn_press_o,
    output logic [N_CH-1:0] btn_release_o,
    output logic [N_CH-1:0] btn_long_o,
    output logic            any_press_o
);

    localparam int              SW        = $clog2(STABLE_CYCLES);
    localparam logic [SW-1:0]   STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [N_CH-1:0] POLARITY  = ACTIVE_LOW ? {N_CH{1'b1}} : {N_CH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_CONF_PRESS   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_CONF_RELEASE = 2'd3
    } state_t;

    logic [N_CH-1:0] sync_a_q;
    logic [N_CH-1:0] sync_b_q;
    logic [N_CH-1:0] press_vec_d;
    logic            any_press_q;

    // Two-flop synchroniser; polarity is normalised so 1 always means pressed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= btn_in_i ^ POLARITY;
            sync_b_q <= sync_a_q;
        end
    end

    // any_press follows the next-state press vector so it lines up with btn_press
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_vec_d;
        end
    end

    assign any_press_o = any_press_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [SW-1:0] stab_q, stab_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        logic          s;

        assign s = sync_b_q[i];

        // Channel FSM state and registered outputs
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q   <= ST_IDLE;
                stab_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                stab_q    <= stab_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        // Stability-window FSM: any opposite sample aborts the confirmation
        always_comb begin
            state_d   = state_q;
            stab_d    = stab_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        state_d = ST_CONF_PRESS;
                        stab_d  = '0;
                    end
                end
                ST_CONF_PRESS: begin
                    if (!s) begin
                        state_d = ST_IDLE;
                    end else if (stab_q == STAB_LAST) begin
                        state_d = ST_PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        state_d = ST_CONF_RELEASE;
                        stab_d  = '0;
                    end
                end
                ST_CONF_RELEASE: begin
                    if (s) begin
                        state_d = ST_PRESSED;
                    end else if (stab_q == STAB_LAST) begin
                        state_d   = ST_IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (LONG_CYCLES > 0) begin : g_long
            localparam int            HW        = $clog2(LONG_CYCLES + 1);
            localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

            logic [HW-1:0] hold_q, hold_d;
            logic          long_done_q, long_done_d;

            // Hold-time counter, frozen once the long strobe has been issued
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hold_q      <= '0;
                    long_done_q <= 1'b0;
                end else begin
                    hold_q      <= hold_d;
                    long_done_q <= long_done_d;
                end
            end

            // Long-press detect; an accepted release on the same edge suppresses it
            always_comb begin
                hold_d      = hold_q;
                long_done_d = long_done_q;
                long_d      = 1'b0;
                if (press_d) begin
                    hold_d      = '0;
                    long_done_d = 1'b0;
                end else if (level_q && !long_done_q &&
                             (state_q == ST_PRESSED || state_q == ST_CONF_RELEASE)) begin
                    if (hold_q == HOLD_LAST) begin
                        long_d      = !release_d;
                        long_done_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
        end else begin : g_no_long
            assign long_d = 1'b0;
        end

        assign press_vec_d[i]   = press_d;
        assign btn_level_o[i]   = level_q;
        assign btn_press_o[i]   = press_q;
        assign btn_release_o[i] = release_q;
        assign btn_long_o[i]    = long_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_button_debounce
// Description : Directed self-checking bench for multi_button_debounce with
//               an active-high instance and an ACTIVE_LOW instance.
//               Edge e is the e-th rising clock edge after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_button_debounce;

    localparam int N_CH   = 2;
    localparam int STABLE = 4;
    localparam int LONG   = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] lvl, prs, rel, lng;
    logic            anyp;
    logic [N_CH-1:0] btn_al;
    logic [N_CH-1:0] lvl_al, prs_al, rel_al, lng_al;
    logic            anyp_al;

    int n_assert = 0;
    int n_fail   = 0;
    int e        = 0;

    always #5 clk = ~clk;

    multi_button_debounce #(
        .N_CH(N_CH), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .btn_in_i(btn),
        .btn_level_o(lvl), .btn_press_o(prs), .btn_release_o(rel),
        .btn_long_o(lng), .any_press_o(anyp)
    );

    multi_button_debounce #(
        .N_CH(N_CH), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk_i(clk), .rst_ni(rst_n), .btn_in_i(btn_al),
        .btn_level_o(lvl_al), .btn_press_o(prs_al), .btn_release_o(rel_al),
        .btn_long_o(lng_al), .any_press_o(anyp_al)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        e += n;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lvl"}, 32'(lvl), 0);
        chk({tag, "_prs"}, 32'(prs), 0);
        chk({tag, "_rel"}, 32'(rel), 0);
        chk({tag, "_lng"}, 32'(lng), 0);
        chk({tag, "_any"}, 32'(anyp), 0);
        chk({tag, "_al_lvl"}, 32'(lvl_al), 0);
        chk({tag, "_al_prs"}, 32'(prs_al), 0);
        chk({tag, "_al_any"}, 32'(anyp_al), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        btn    = 2'b00;
        btn_al = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        e     = 0;

        // Clean press on channel 0: raw rises before edge 10, accepted at edge 16
        adv(9);
        btn[0] = 1'b1;
        adv(6);
        chk("press_e15_prs", 32'(prs), 0);
        chk("press_e15_lvl", 32'(lvl), 0);
        adv(1);
        chk("press_e16_prs", 32'(prs), 32'h1);
        chk("press_e16_any", 32'(anyp), 1);
        chk("press_e16_lvl", 32'(lvl), 32'h1);
        chk("press_e16_rel", 32'(rel), 0);
        adv(1);
        chk("press_e17_prs", 32'(prs), 0);
        chk("press_e17_any", 32'(anyp), 0);
        chk("press_e17_lvl", 32'(lvl), 32'h1);

        // Release glitch (2 low cycles) while pressed; hold counting continues
        while (e < 35) begin
            if (e == 20) btn[0] = 1'b0;
            if (e == 22) btn[0] = 1'b1;
            adv(1);
            chk("glitch_lvl", 32'(lvl), 32'h1);
            chk("glitch_rel", 32'(rel), 0);
            chk("glitch_lng", 32'(lng), 0);
        end
        adv(1);
        chk("long_e36", 32'(lng), 32'h1);

        // Drop before edge 50: release accepted at edge 56, no second long
        while (e < 60) begin
            if (e == 49) btn[0] = 1'b0;
            adv(1);
            chk("rel_lng", 32'(lng), 0);
            chk("rel_prs", 32'(prs), 0);
            chk("rel_rel", 32'(rel), (e == 56) ? 32'h1 : 32'h0);
            chk("rel_lvl", 32'(lvl), (e < 56) ? 32'h1 : 32'h0);
        end

        // Bounce on channel 1: five 3-cycle highs are all rejected
        for (int rep = 0; rep < 5; rep++) begin
            btn[1] = 1'b1;
            repeat (3) begin
                adv(1);
                chk("bounce_hi_prs", 32'(prs), 0);
                chk("bounce_hi_lvl", 32'(lvl), 0);
                chk("bounce_hi_any", 32'(anyp), 0);
            end
            btn[1] = 1'b0;
            repeat (3) begin
                adv(1);
                chk("bounce_lo_prs", 32'(prs), 0);
                chk("bounce_lo_lvl", 32'(lvl), 0);
            end
        end
        // Final rise just after edge 90 is held: press at edge 97
        btn[1] = 1'b1;
        adv(6);
        chk("ch1_e96_prs", 32'(prs), 0);
        adv(1);
        chk("ch1_e97_prs", 32'(prs), 32'h2);
        chk("ch1_e97_any", 32'(anyp), 1);
        chk("ch1_e97_lvl", 32'(lvl), 32'h2);
        adv(1);
        chk("ch1_e98_prs", 32'(prs), 0);
        chk("ch1_e98_any", 32'(anyp), 0);

        // ACTIVE_LOW instance: both inputs fall together
        btn_al = 2'b00;
        adv(6);
        chk("al_e104_prs", 32'(prs_al), 0);
        adv(1);
        chk("al_e105_prs", 32'(prs_al), 32'h3);
        chk("al_e105_any", 32'(anyp_al), 1);
        chk("al_e105_lvl", 32'(lvl_al), 32'h3);
        adv(1);
        chk("al_e106_prs", 32'(prs_al), 0);
        chk("al_e106_any", 32'(anyp_al), 0);
        chk("al_e106_lvl", 32'(lvl_al), 32'h3);

        // Reset with channel 0 in CONF_PRESS and channel 1 pressed
        btn[0] = 1'b1;
        adv(3);
        chk("pre_rst_lvl", 32'(lvl), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        e     = 0;

        // Buttons still held: each re-debounced from IDLE, one press at edge 7
        adv(6);
        chk("rerun_e6_prs", 32'(prs), 0);
        chk("rerun_e6_lvl", 32'(lvl), 0);
        chk("rerun_e6_al_prs", 32'(prs_al), 0);
        adv(1);
        chk("rerun_e7_prs", 32'(prs), 32'h3);
        chk("rerun_e7_any", 32'(anyp), 1);
        chk("rerun_e7_lvl", 32'(lvl), 32'h3);
        chk("rerun_e7_al_prs", 32'(prs_al), 32'h3);
        while (e < 15) begin
            adv(1);
            chk("rerun_tail_prs", 32'(prs), 0);
            chk("rerun_tail_any", 32'(anyp), 0);
            chk("rerun_tail_lvl", 32'(lvl), 32'h3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
